// File: rtl/fixed_point_divider_pkg.sv
// Shared types and helpers for the fixed-point divider: FSM state encoding and
// the saturation limit applied to the quotient magnitude.
package fixed_point_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam int unsigned SAT_W = 64;

  // Largest representable result magnitude: unsigned all-ones, signed 2^(w-1)-1
  // for positive results and 2^(w-1) for negative ones.
  function automatic logic [SAT_W-1:0] sat_limit(input int unsigned width,
                                                 input logic        is_signed,
                                                 input logic        negative);
    logic [SAT_W-1:0] one;
    one = SAT_W'(1);
    if (!is_signed) return (one << width) - one;
    if (negative)   return one << (width - 1);
    return (one << (width - 1)) - one;
  endfunction

endpackage

// File: rtl/adder.sv
// Width-parameterised adder with carry in/out; USE_CLA picks a lookahead-style
// (tool-optimised) carry structure or an explicit ripple chain.
module adder #(
  parameter int W       = 32,
  parameter int USE_CLA = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  if (USE_CLA != 0) begin : g_cla
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
  end else begin : g_ripple
    always_comb begin
      logic carry;
      carry = cin_i;
      sum_o = '0;
      for (int i = 0; i < W; i++) begin
        sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
        carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
      cout_o = carry;
    end
  end

endmodule

// File: rtl/fixed_point_divider_div_step.sv
// One restoring-division step: shift the next dividend bit into the remainder,
// trial-subtract the divisor and keep the difference only if it is non-negative.
module div_step #(
  parameter int W       = 32,
  parameter int USE_CLA = 1
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);

  logic [W:0] shifted;
  logic [W:0] diff;
  logic       no_borrow;

  assign shifted = {rem_i[W-1:0], bit_i};

  adder #(.W(W + 1), .USE_CLA(USE_CLA)) u_sub (
    .a_i   (shifted),
    .b_i   (~{1'b0, dvs_i}),
    .cin_i (1'b1),
    .sum_o (diff),
    .cout_o(no_borrow)
  );

  // A set remainder MSB means the true shifted value already exceeds any divisor.
  assign q_o   = no_borrow | rem_i[W];
  assign rem_o = q_o ? diff : shifted;

endmodule

// File: rtl/sign_converter.sv
// Conditional two's-complement negation, used both to take magnitudes and to
// re-sign the quotient.
module sign_converter #(
  parameter int W = 32
) (
  input  logic [W-1:0] value_i,
  input  logic         negate_i,
  output logic [W-1:0] result_o
);

  assign result_o = negate_i ? (~value_i + W'(1)) : value_i;

endmodule

// File: rtl/fixed_point_divider.sv
// Multi-cycle restoring divider computing y = (a << FIXED_POINT) / b in Q-format,
// with saturation and divide-by-zero flags, sharing the multiplier's handshake.
module fixed_point_divider
  import fixed_point_divider_pkg::*;
#(
  parameter int C_WIDTH     = 32,
  parameter int FIXED_POINT = 8,
  parameter int USE_CLA     = 1
) (
  input  logic               ctl_clk,
  input  logic               reset,
  input  logic [C_WIDTH-1:0] a,
  input  logic [C_WIDTH-1:0] b,
  input  logic               signed_cal,
  input  logic               trigger,
  output logic               ready,
  output logic               done,
  output logic [C_WIDTH-1:0] y,
  output logic               div_zero,
  output logic               overflow
);

  localparam int N  = C_WIDTH + FIXED_POINT;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);
  localparam int MSB = C_WIDTH - 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N-1:0]       dvd_q, dvd_d;
  logic [C_WIDTH:0]   rem_q, rem_d;
  logic [N-1:0]       quo_q, quo_d;
  logic [C_WIDTH-1:0] dvs_q, dvs_d;
  logic               signed_q, signed_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_a_q, neg_a_d;
  logic               bzero_q, bzero_d;
  logic [C_WIDTH-1:0] y_q, y_d;
  logic               dz_q, dz_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [C_WIDTH-1:0] a_mag, b_mag, res_mag, res_signed;
  logic [C_WIDTH:0]   rem_step;
  logic               q_bit, res_neg, over;
  logic [SAT_W-1:0]   sat_sel;

  sign_converter #(.W(C_WIDTH)) u_mag_a (
    .value_i(a), .negate_i(a[MSB] & signed_cal), .result_o(a_mag)
  );
  sign_converter #(.W(C_WIDTH)) u_mag_b (
    .value_i(b), .negate_i(b[MSB] & signed_cal), .result_o(b_mag)
  );

  div_step #(.W(C_WIDTH), .USE_CLA(USE_CLA)) u_step (
    .rem_i(rem_q), .bit_i(dvd_q[N-1]), .dvs_i(dvs_q), .rem_o(rem_step), .q_o(q_bit)
  );

  // Divide-by-zero saturates on the dividend's sign, otherwise on the quotient's.
  assign res_neg = bzero_q ? neg_a_q : neg_res_q;
  assign sat_sel = sat_limit(C_WIDTH, signed_q, res_neg);
  assign over    = SAT_W'(quo_q) > sat_sel;
  assign res_mag = (bzero_q | over) ? sat_sel[C_WIDTH-1:0] : quo_q[C_WIDTH-1:0];

  sign_converter #(.W(C_WIDTH)) u_resign (
    .value_i(res_mag), .negate_i(res_neg), .result_o(res_signed)
  );

  always_comb begin
    // NOTE: every next-state value defaults to its register so no path infers a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    signed_d  = signed_q;
    neg_res_d = neg_res_q;
    neg_a_d   = neg_a_q;
    bzero_d   = bzero_q;
    y_d       = y_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          dvd_d     = {a_mag, {FIXED_POINT{1'b0}}};
          dvs_d     = b_mag;
          signed_d  = signed_cal;
          neg_res_d = (a[MSB] ^ b[MSB]) & signed_cal;
          neg_a_d   = a[MSB] & signed_cal;
          bzero_d   = (b == '0);
          rem_d     = '0;
          quo_d     = '0;
          cnt_d     = CNT_LOAD;
          state_d   = (b == '0) ? ST_FINISH : ST_CALC;
        end
      end
      ST_CALC: begin
        dvd_d = {dvd_q[N-2:0], 1'b0};
        rem_d = rem_step;
        quo_d = {quo_q[N-2:0], q_bit};
        if (cnt_q == '0) state_d = ST_FINISH;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_FINISH: begin
        y_d     = res_signed;
        dz_d    = bzero_q;
        ovf_d   = ~bzero_q & over;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ctl_clk or posedge reset) begin
    // NOTE: registers update with <= so every flop samples pre-edge values.
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      signed_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      bzero_q   <= 1'b0;
      y_q       <= '0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      signed_q  <= signed_d;
      neg_res_q <= neg_res_d;
      neg_a_q   <= neg_a_d;
      bzero_q   <= bzero_d;
      y_q       <= y_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign ready    = (state_q == ST_IDLE);
  assign done     = done_q;
  assign y        = y_q;
  assign div_zero = dz_q;
  assign overflow = ovf_q;

endmodule
